// File: rtl/uart_tx_if.sv
// Parallel request / serial line bundle between a byte producer and uart_tx.
// The master side owns the request and configuration; the slave side owns the line and busy.
interface uart_tx_if #(
    parameter int PRESCALE_W = 6
);
    logic [7:0]            p_data;
    logic                  data_valid;
    logic                  par_en;
    logic                  par_typ;
    logic [PRESCALE_W-1:0] prescale;
    logic                  tx_out;
    logic                  busy;

    modport master (
        output p_data, data_valid, par_en, par_typ, prescale,
        input  tx_out, busy
    );

    modport slave (
        input  p_data, data_valid, par_en, par_typ, prescale,
        output tx_out, busy
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, stop bit.
// Each bit is held for a latched prescale count of clk cycles; all outputs are registered.
module uart_tx #(
    parameter int PRESCALE_W = 6
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [PRESCALE_W-1:0] P_ONE = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] P_TWO = PRESCALE_W'(2);

    state_t                state, state_n;
    logic [PRESCALE_W-1:0] edge_cnt, edge_n;
    logic [PRESCALE_W-1:0] edge_last, edge_last_n;
    logic [2:0]            bit_cnt, bit_n;
    logic [7:0]            data_q, data_n;
    logic                  par_en_q, par_en_n;
    logic                  par_typ_q, par_typ_n;
    logic                  tx_q, tx_n;
    logic                  busy_q, busy_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            edge_cnt  <= '0;
            edge_last <= '0;
            bit_cnt   <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_n;
            edge_cnt  <= edge_n;
            edge_last <= edge_last_n;
            bit_cnt   <= bit_n;
            data_q    <= data_n;
            par_en_q  <= par_en_n;
            par_typ_q <= par_typ_n;
            tx_q      <= tx_n;
            busy_q    <= busy_n;
        end
    end

    always_comb begin
        state_n     = state;
        edge_n      = edge_cnt;
        edge_last_n = edge_last;
        bit_n       = bit_cnt;
        data_n      = data_q;
        par_en_n    = par_en_q;
        par_typ_n   = par_typ_q;
        tx_n        = tx_q;
        busy_n      = busy_q;

        if (state == IDLE) begin
            if (bus.data_valid) begin
                state_n     = START;
                edge_n      = '0;
                // Store P-1 directly so the wrap compare needs no subtractor per cycle.
                edge_last_n = (bus.prescale < P_TWO) ? P_ONE : bus.prescale - P_ONE;
                data_n      = bus.p_data;
                par_en_n    = bus.par_en;
                par_typ_n   = bus.par_typ;
                tx_n        = 1'b0;
                busy_n      = 1'b1;
            end
        end else if (edge_cnt != edge_last) begin
            edge_n = edge_cnt + P_ONE;
        end else begin
            edge_n = '0;
            unique case (state)
                START: begin
                    state_n = DATA;
                    bit_n   = 3'd0;
                    tx_n    = data_q[0];
                end
                DATA: begin
                    if (bit_cnt == 3'd7) begin
                        state_n = par_en_q ? PARITY : STOP;
                        tx_n    = par_en_q ? (^data_q ^ par_typ_q) : 1'b1;
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                        tx_n  = data_q[bit_n];
                    end
                end
                PARITY: begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                end
                STOP: begin
                    state_n = IDLE;
                    tx_n    = 1'b1;
                    busy_n  = 1'b0;
                end
                default: begin
                    state_n = IDLE;
                    tx_n    = 1'b1;
                    busy_n  = 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_out = tx_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_uart_tx.sv
// Randomised and directed frames against a bit-list reference; a negedge monitor
// pops expected frames from a scoreboard queue whenever busy rises.
module tb_uart_tx;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_if #(.PRESCALE_W(6)) bus ();
    uart_tx #(.PRESCALE_W(6)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        logic [7:0] data;
        bit         pe;
        bit         pt;
        int         p;
        int         len;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   issued = 0;
    int   frames_seen = 0;
    int   idle_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Line level expected at cycle cyc of a frame, from the frame's bit list.
    function automatic logic exp_bit(input exp_t e, input int cyc);
        int idx;
        idx = cyc / e.p;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return e.data[idx-1];
        if (idx == 9 && e.pe) return logic'($countones(e.data) % 2) ^ e.pt;
        return 1'b1;
    endfunction

    function automatic exp_t mk(input logic [7:0] d, input bit pe, input bit pt, input int ps);
        exp_t e;
        e.data = d;
        e.pe   = pe;
        e.pt   = pt;
        e.p    = (ps < 2) ? 2 : ps;
        e.len  = (pe ? 11 : 10) * e.p;
        return e;
    endfunction

    task automatic setin(input logic [7:0] d, input bit pe, input bit pt, input int ps);
        bus.p_data   = d;
        bus.par_en   = pe;
        bus.par_typ  = pt;
        bus.prescale = 6'(ps);
    endtask

    task automatic push(input exp_t e);
        sbq.push_back(e);
        issued++;
    endtask

    task automatic waitc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Single-cycle request, then wait until the frame has left the line.
    task automatic send(input logic [7:0] d, input bit pe, input bit pt, input int ps, input int gap);
        exp_t e;
        e = mk(d, pe, pt, ps);
        setin(d, pe, pt, ps);
        bus.data_valid = 1'b1;
        push(e);
        waitc(1);
        bus.data_valid = 1'b0;
        waitc(e.len + gap);
    endtask

    // Monitor
    initial begin
        exp_t cur;
        bit   in_frame;
        int   cnt;
        int   wave_err;
        in_frame = 0;
        cnt = 0;
        wave_err = 0;
        forever begin
            @(negedge clk);
            if (!in_frame) begin
                if (bus.busy === 1'b1) begin
                    chk("frame_expected", int'(sbq.size() > 0), 1);
                    if (sbq.size() > 0) cur = sbq.pop_front();
                    else cur = '{data: 8'h00, pe: 1'b0, pt: 1'b0, p: 1, len: 0};
                    in_frame = 1;
                    cnt = 0;
                    wave_err = 0;
                end else if (bus.tx_out !== 1'b1) begin
                    idle_err++;
                end
            end
            if (in_frame) begin
                if (bus.busy === 1'b1) begin
                    if (bus.tx_out !== exp_bit(cur, cnt)) begin
                        if (wave_err == 0)
                            $display("FAIL wave_bit data=%02h cyc=%0d act=%b exp=%b",
                                     cur.data, cnt, bus.tx_out, exp_bit(cur, cnt));
                        wave_err++;
                    end
                    cnt++;
                end else begin
                    chk("frame_wave", wave_err, 0);
                    chk("frame_len", cnt, cur.len);
                    frames_seen++;
                    in_frame = 0;
                    if (bus.tx_out !== 1'b1) idle_err++;
                end
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        exp_t e;
        // 1: reset held with a request pending
        rst = 1'b1;
        setin(8'h3C, 1'b0, 1'b0, 4);
        bus.data_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_tx", int'(bus.tx_out), 1);
            chk("rst_busy", int'(bus.busy), 0);
        end
        rst = 1'b0;
        push(mk(8'h3C, 1'b0, 1'b0, 4));
        #1;
        chk("rel_tx", int'(bus.tx_out), 1);
        chk("rel_busy", int'(bus.busy), 0);
        waitc(1);
        bus.data_valid = 1'b0;
        waitc(40 + 2);

        // 2: plain frame
        send(8'hA5, 1'b0, 1'b0, 8, 2);
        // 3, 4: parity polarities at longer bit periods
        send(8'hA5, 1'b1, 1'b0, 16, 2);
        send(8'hA5, 1'b1, 1'b1, 16, 2);
        send(8'h07, 1'b1, 1'b0, 32, 2);
        send(8'h07, 1'b1, 1'b1, 32, 2);

        // 5: request during a frame must be dropped and must not alter it
        e = mk(8'h5A, 1'b0, 1'b0, 8);
        setin(8'h5A, 1'b0, 1'b0, 8);
        bus.data_valid = 1'b1;
        push(e);
        waitc(1);
        bus.data_valid = 1'b0;
        waitc(30);
        setin(8'h3C, 1'b1, 1'b1, 16);
        bus.data_valid = 1'b1;
        waitc(1);
        bus.data_valid = 1'b0;
        waitc(80 + 40);

        // held data_valid re-triggers in the first idle cycle
        setin(8'hC3, 1'b0, 1'b0, 4);
        bus.data_valid = 1'b1;
        push(mk(8'hC3, 1'b0, 1'b0, 4));
        waitc(1);
        setin(8'h96, 1'b1, 1'b1, 4);
        push(mk(8'h96, 1'b1, 1'b1, 4));
        waitc(41);
        bus.data_valid = 1'b0;
        waitc(44 + 3);

        // clamped prescale and random frames
        send(8'h81, 1'b1, 1'b0, 0, 1);
        send(8'h18, 1'b0, 1'b0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            send(8'($urandom), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                 int'($urandom_range(0, 12)), int'($urandom_range(0, 3)));
        end

        // 6: reset in the middle of data bit 4 at P=16
        e = mk(8'hA5, 1'b0, 1'b0, 16);
        e.len = 88;
        setin(8'hA5, 1'b0, 1'b0, 16);
        bus.data_valid = 1'b1;
        push(e);
        waitc(1);
        bus.data_valid = 1'b0;
        waitc(87);
        rst = 1'b1;
        waitc(1);
        rst = 1'b0;
        chk("abort_tx", int'(bus.tx_out), 1);
        chk("abort_busy", int'(bus.busy), 0);
        waitc(2);
        send(8'hFF, 1'b0, 1'b0, 16, 4);

        chk("idle_line", idle_err, 0);
        chk("queue_empty", sbq.size(), 0);
        chk("frames_seen", frames_seen, issued);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART serial transmitter; the transmit-side counterpart of the team's UART receiver.
- Takes an 8-bit parallel byte through a single-cycle valid/busy handshake and serialises it as a frame: start bit, 8 data bits LSB first, optional parity bit, stop bit.
- Bit period is set by the same prescale input the receiver uses (clk cycles per bit), so TX and RX share one clock and configuration bus.

Parameters:
PRESCALE_W, 6, width of prescale input; supports 8/16/32 cycles per bit and any value 2..2^PRESCALE_W-1.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
p_data  input  8  byte to transmit, bit 0 sent first
data_valid  input  1  request pulse; accepted only when busy=0
par_en  input  1  1 = append parity bit
par_typ  input  1  0 = even parity, 1 = odd parity
prescale  input  PRESCALE_W  clk cycles per bit; values 0 and 1 treated as 2
tx_out  output  1  serial line, idle high
busy  output  1  frame in progress; data_valid ignored while high

Behaviour:
- Reset: synchronous, active-high; sampled on rising clk edge.
- Reset values: tx_out=1, busy=0, state=IDLE, edge and bit counters=0, holding registers=0.
- Reset mid-frame: the frame is aborted with no partial stop bit. The cycle after rst is sampled high shows tx_out=1 and busy=0.
- All outputs are registered.
- States: IDLE, START, DATA, PARITY, STOP.
- Accept: at an edge where state=IDLE and data_valid=1, register p_data, par_en, par_typ and prescale into holding registers, and enter START. From the next cycle, tx_out=0 and busy=1. Later changes to any input have no effect on the frame in flight.
- Edge counter: counts 0..P-1 in every non-IDLE state, where P is the latched prescale (clamped to at least 2). Each bit is held on tx_out for exactly P cycles. At count P-1 the counter wraps to 0 and the state advances.
- START -> DATA.
- DATA:
  - tx_out = data[bit_cnt], with bit_cnt running 0..7.
  - After bit 7 the state goes to PARITY if par_en is latched, else to STOP.
  - bit_cnt clears on entry to DATA.
- PARITY: tx_out = ^data when par_typ=0, ~^data when par_typ=1.
- STOP: tx_out=1 for P cycles, then IDLE. busy=0 from the first IDLE cycle.
- Frame length: 10*P cycles with par_en=0, 11*P cycles with par_en=1. busy is high for exactly that many cycles.
- Back-to-back frames: data_valid may be asserted in the first IDLE cycle after STOP. The line therefore stays high for at least P+1 cycles between frames.
- data_valid while busy=1 is dropped; there is no queueing and no error flag.
- data_valid held high continuously re-triggers a new frame on every IDLE cycle.
- No combinational path from any input to any output.

Test Plan:
1. Assert rst for 3 cycles, with data_valid=1 during reset -> tx_out=1 and busy=0 throughout and for 1 cycle after release. The frame then starts from the data_valid still held high.
2. p_data=0xA5, par_en=0, prescale=8, one-cycle data_valid:
   - tx_out sequence, 8 cycles each: 0 | 1,0,1,0,0,1,0,1 | 1.
   - busy high for exactly 80 cycles, then low.
3. p_data=0xA5 (four ones), par_en=1, prescale=16:
   - par_typ=0 -> parity bit 0.
   - par_typ=1 -> parity bit 1.
   - Frame is 176 cycles in both cases.
4. p_data=0x07 (three ones), par_en=1, prescale=32:
   - par_typ=0 -> parity bit 1.
   - par_typ=1 -> parity bit 0.
   - Frame is 352 cycles in both cases.
5. Start 0x5A with prescale=8. During DATA, pulse data_valid with p_data=0x3C and toggle par_en/prescale -> the transmitted frame is unchanged 0x5A, 80 cycles, and no second frame follows.
6. Assert rst for 1 cycle during data bit 4 of a prescale=16 frame -> tx_out=1 and busy=0 on the next cycle. A new request for 0xFF then produces a clean 160-cycle frame.
